// File: rtl/cmplx_fxp_multiplier.sv
// Pipelined signed fixed-point complex multiplier: P = A * B.
// Three register stages: operand capture, partial products, then
// combine/round/range-check into the output registers.
// Rounding adds 2^(FRACTION-1) before the arithmetic shift, which rounds
// half toward +inf. Define CMPLX_MULT_SATURATE_EN to clamp out-of-range
// components; otherwise they wrap to the low WORD_SIZE bits.
// o_ovf is produced the same way in both builds.
module cmplx_fxp_multiplier #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned FRACTION  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [WORD_SIZE-1:0] i_ar,
    input  logic [WORD_SIZE-1:0] i_ai,
    input  logic [WORD_SIZE-1:0] i_br,
    input  logic [WORD_SIZE-1:0] i_bi,
    output logic                 o_valid,
    output logic [WORD_SIZE-1:0] o_pr,
    output logic [WORD_SIZE-1:0] o_pi,
    output logic                 o_ovf
);

    localparam int unsigned PW = 2 * WORD_SIZE;  // product width
    localparam int unsigned SW = PW + 1;         // sum width, cannot overflow

    // Stage 1 state
    logic signed [WORD_SIZE-1:0] ar_d, ar_q, ai_d, ai_q, br_d, br_q, bi_d, bi_q;
    logic                        vld1_d, vld1_q;
    // Stage 2 state
    logic signed [PW-1:0]        p_rr_d, p_rr_q, p_ii_d, p_ii_q;
    logic signed [PW-1:0]        p_ri_d, p_ri_q, p_ir_d, p_ir_q;
    logic                        vld2_d, vld2_q;
    // Stage 3 combinational and output state
    logic signed [SW-1:0]        rnd, sum_re, sum_im, sh_re, sh_im;
    logic                        ovf_re, ovf_im;
    logic [WORD_SIZE-1:0]        res_re, res_im;
    logic [WORD_SIZE-1:0]        o_pr_d, o_pr_q, o_pi_d, o_pi_q;
    logic                        o_ovf_d, o_ovf_q, o_valid_d, o_valid_q;

    // Operand capture; data loads every cycle, only valid matters downstream.
    always_comb begin
        ar_d   = i_ar;
        ai_d   = i_ai;
        br_d   = i_br;
        bi_d   = i_bi;
        vld1_d = i_valid;
    end

    // Four signed full-width partial products.
    always_comb begin
        p_rr_d = PW'(ar_q) * PW'(br_q);
        p_ii_d = PW'(ai_q) * PW'(bi_q);
        p_ri_d = PW'(ar_q) * PW'(bi_q);
        p_ir_d = PW'(ai_q) * PW'(br_q);
        vld2_d = vld1_q;
    end

    // Combine, round, shift, range-check and select the output values.
    always_comb begin
        rnd                = '0;
        rnd[FRACTION-1]    = 1'b1;
        sum_re             = SW'(p_rr_q) - SW'(p_ii_q) + rnd;
        sum_im             = SW'(p_ri_q) + SW'(p_ir_q) + rnd;
        sh_re              = sum_re >>> FRACTION;
        sh_im              = sum_im >>> FRACTION;
        // In range iff every bit from the result sign upward matches.
        ovf_re             = !((&sh_re[SW-1:WORD_SIZE-1]) || !(|sh_re[SW-1:WORD_SIZE-1]));
        ovf_im             = !((&sh_im[SW-1:WORD_SIZE-1]) || !(|sh_im[SW-1:WORD_SIZE-1]));
        res_re             = sh_re[WORD_SIZE-1:0];
        res_im             = sh_im[WORD_SIZE-1:0];
`ifdef CMPLX_MULT_SATURATE_EN
        if (ovf_re) begin
            res_re = sh_re[SW-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                 : {1'b0, {(WORD_SIZE-1){1'b1}}};
        end
        if (ovf_im) begin
            res_im = sh_im[SW-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                 : {1'b0, {(WORD_SIZE-1){1'b1}}};
        end
`endif
        // Outputs hold the last result while no new one is available.
        o_pr_d             = vld2_q ? res_re : o_pr_q;
        o_pi_d             = vld2_q ? res_im : o_pi_q;
        o_ovf_d            = vld2_q ? (ovf_re | ovf_im) : o_ovf_q;
        o_valid_d          = vld2_q;
    end

    // Pipeline registers, all cleared by asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ar_q      <= '0;
            ai_q      <= '0;
            br_q      <= '0;
            bi_q      <= '0;
            vld1_q    <= 1'b0;
            p_rr_q    <= '0;
            p_ii_q    <= '0;
            p_ri_q    <= '0;
            p_ir_q    <= '0;
            vld2_q    <= 1'b0;
            o_pr_q    <= '0;
            o_pi_q    <= '0;
            o_ovf_q   <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            ar_q      <= ar_d;
            ai_q      <= ai_d;
            br_q      <= br_d;
            bi_q      <= bi_d;
            vld1_q    <= vld1_d;
            p_rr_q    <= p_rr_d;
            p_ii_q    <= p_ii_d;
            p_ri_q    <= p_ri_d;
            p_ir_q    <= p_ir_d;
            vld2_q    <= vld2_d;
            o_pr_q    <= o_pr_d;
            o_pi_q    <= o_pi_d;
            o_ovf_q   <= o_ovf_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_pr    = o_pr_q;
    assign o_pi    = o_pi_q;
    assign o_ovf   = o_ovf_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_cmplx_fxp_multiplier.sv
// Scoreboard bench for cmplx_fxp_multiplier (WORD_SIZE=16, FRACTION=8).
module tb_cmplx_fxp_multiplier;

    localparam int W = 16;
    localparam int F = 8;

    typedef struct {
        logic [W-1:0] pr;
        logic [W-1:0] pi;
        logic         ovf;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid = 1'b0;
    logic [W-1:0] i_ar = '0, i_ai = '0, i_br = '0, i_bi = '0;
    logic         o_valid;
    logic [W-1:0] o_pr, o_pi;
    logic         o_ovf;

    exp_t         sb[$];
    logic [2:0]   vpipe;
    logic [W-1:0] hold_pr = '0, hold_pi = '0;
    int           n_checks = 0;
    int           n_fail = 0;

    cmplx_fxp_multiplier #(
        .WORD_SIZE(W),
        .FRACTION (F)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .i_ar   (i_ar),
        .i_ai   (i_ai),
        .i_br   (i_br),
        .i_bi   (i_bi),
        .o_valid(o_valid),
        .o_pr   (o_pr),
        .o_pi   (o_pi),
        .o_ovf  (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-accurate reference: widen, round half up, arithmetic shift, narrow.
    function automatic exp_t model(input logic [W-1:0] ar, input logic [W-1:0] ai,
                                   input logic [W-1:0] br, input logic [W-1:0] bi);
        exp_t   e;
        longint sar, sai, sbr, sbi, re, im, lo, hi;
        logic   ov_r, ov_i;
        sar = longint'($signed(ar));
        sai = longint'($signed(ai));
        sbr = longint'($signed(br));
        sbi = longint'($signed(bi));
        re  = (sar * sbr - sai * sbi + (longint'(1) << (F - 1))) >>> F;
        im  = (sar * sbi + sai * sbr + (longint'(1) << (F - 1))) >>> F;
        hi  = (longint'(1) << (W - 1)) - 1;
        lo  = -(longint'(1) << (W - 1));
        ov_r = (re > hi) || (re < lo);
        ov_i = (im > hi) || (im < lo);
        e.pr = re[W-1:0];
        e.pi = im[W-1:0];
`ifdef CMPLX_MULT_SATURATE_EN
        if (re > hi) e.pr = hi[W-1:0];
        if (re < lo) e.pr = lo[W-1:0];
        if (im > hi) e.pi = hi[W-1:0];
        if (im < lo) e.pi = lo[W-1:0];
`endif
        e.ovf = ov_r | ov_i;
        return e;
    endfunction

    // Expected o_valid: i_valid delayed by three edges, cleared by reset.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vpipe <= '0;
        else       vpipe <= {vpipe[1:0], i_valid};
    end

    // Output monitor, samples just after the rising edge.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (!i_rst) begin
            check_eq("o_valid", {31'd0, o_valid}, {31'd0, vpipe[2]});
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("o_pr", {16'd0, o_pr}, {16'd0, e.pr});
                    check_eq("o_pi", {16'd0, o_pi}, {16'd0, e.pi});
                    check_eq("o_ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
                    hold_pr = e.pr;
                    hold_pi = e.pi;
                end
            end else begin
                check_eq("hold_pr", {16'd0, o_pr}, {16'd0, hold_pr});
                check_eq("hold_pi", {16'd0, o_pi}, {16'd0, hold_pi});
            end
        end
    end

    task automatic drive_exp(input logic [W-1:0] ar, input logic [W-1:0] ai,
                             input logic [W-1:0] br, input logic [W-1:0] bi, input exp_t e);
        i_ar = ar; i_ai = ai; i_br = br; i_bi = bi; i_valid = 1'b1;
        sb.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic drive(input logic [W-1:0] ar, input logic [W-1:0] ai,
                         input logic [W-1:0] br, input logic [W-1:0] bi);
        drive_exp(ar, ai, br, bi, model(ar, ai, br, bi));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b0;
            i_ar = W'($urandom); i_ai = W'($urandom);
            i_br = W'($urandom); i_bi = W'($urandom);
            @(negedge i_clk);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] pr, input logic [W-1:0] pi, input logic ovf);
        exp_t e;
        e.pr = pr; e.pi = pi; e.ovf = ovf;
        return e;
    endfunction

    initial begin
        logic [W-1:0] ovf_res;
`ifdef CMPLX_MULT_SATURATE_EN
        ovf_res = 16'h7FFF;
`else
        ovf_res = 16'h0100;
`endif
        repeat (2) @(negedge i_clk);
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_pr", {16'd0, o_pr}, 32'd0);
        check_eq("rst_pi", {16'd0, o_pi}, 32'd0);
        check_eq("rst_ovf", {31'd0, o_ovf}, 32'd0);
        i_rst = 1'b0;

        // Directed cases with hand-derived results, first one right after release.
        drive_exp(16'h0100, 16'h0000, 16'h0080, 16'h0080, mk(16'h0080, 16'h0080, 1'b0));
        idle(3);
        drive_exp(16'hFE80, 16'h0200, 16'h0200, 16'hFF00, mk(16'hFF00, 16'h0580, 1'b0));
        drive_exp(16'h0001, 16'h0000, 16'h0080, 16'h0000, mk(16'h0001, 16'h0000, 1'b0));
        drive_exp(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, mk(16'h0000, 16'h0000, 1'b0));
        drive_exp(16'h7F00, 16'h0000, 16'h7F00, 16'h7F00, mk(ovf_res, ovf_res, 1'b1));
        // Extremes: widest positive and negative intermediates.
        drive(16'h8000, 16'h0000, 16'h8000, 16'h0000);
        drive(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        drive(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF);
        drive(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF);
        idle(2);

        // Streaming: 8 on, 2 off, 1 on.
        for (int k = 0; k < 8; k++) drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        idle(2);
        drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        idle(5);

        // Reset with two results in flight; previous output is nonzero.
        drive(16'h0300, 16'h0100, 16'h0200, 16'h0100);
        idle(3);
        drive(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        drive(16'h0200, 16'h0100, 16'h0100, 16'h0200);
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("mid_rst_pr", {16'd0, o_pr}, 32'd0);
        check_eq("mid_rst_pi", {16'd0, o_pi}, 32'd0);
        check_eq("mid_rst_ovf", {31'd0, o_ovf}, 32'd0);
        sb.delete();
        hold_pr = '0;
        hold_pi = '0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        idle(5);
        drive(16'h0180, 16'hFF40, 16'h0240, 16'h0060);
        idle(6);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
